microwave_timer: RTL and testbench



---
 rtl/microwave_timer_if.sv | 23 ++
 rtl/microwave_timer.sv | 101 ++++++++++
 tb/tb_microwave_timer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/microwave_timer_if.sv
// Keypad, control and display bundle for the microwave countdown timer.
// The controller side drives the master view, the timer itself is the slave.
interface microwave_timer_if;
  logic       clearn;
  logic [3:0] digit;
  logic       digit_valid;
  logic       enable;
  logic [3:0] min_tens;
  logic [3:0] min_units;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;
  logic       timer_done;

  modport master (
    output clearn, digit, digit_valid, enable,
    input  min_tens, min_units, sec_tens, sec_units, timer_done
  );

  modport slave (
    input  clearn, digit, digit_valid, enable,
    output min_tens, min_units, sec_tens, sec_units, timer_done
  );
endinterface

// File: rtl/microwave_timer.sv
// BCD MM:SS countdown timer with keypad shift-in entry.
// Counting is gated by the magnetron enable; timer_done flags 00:00.
module microwave_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  microwave_timer_if.slave bus
);
  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX =
    PW'(TICKS_PER_SEC - 1);

  logic [3:0]    r_mt, r_mu, r_st, r_su;
  logic [PW-1:0] r_pre;
  logic          r_done;

  logic [3:0]    w_mt, w_mu, w_st, w_su;
  logic [PW-1:0] w_pre;
  logic          w_zero;
  logic          w_accept;
  logic          w_run;
  logic          w_done;

  assign w_zero = ({r_mt, r_mu, r_st, r_su} == 16'h0);

  assign w_accept = bus.digit_valid && !bus.enable &&
                    (bus.digit <= 4'd9);

  assign w_run = bus.enable && !w_zero;

  always_comb begin
    w_mt  = r_mt;
    w_mu  = r_mu;
    w_st  = r_st;
    w_su  = r_su;
    w_pre = r_pre;
    if (!bus.clearn) begin
      w_mt  = 4'd0;
      w_mu  = 4'd0;
      w_st  = 4'd0;
      w_su  = 4'd0;
      w_pre = '0;
    end else if (w_accept) begin
      w_mt  = r_mu;
      w_mu  = r_st;
      w_st  = r_su;
      w_su  = bus.digit;
      w_pre = '0;
    end else if (w_run) begin
      if (r_pre == PMAX) begin
        w_pre = '0;
        // Borrow chain; sec_tens may exceed 5 after entry
        if (r_su != 4'd0) begin
          w_su = r_su - 4'd1;
        end else if (r_st != 4'd0) begin
          w_st = r_st - 4'd1;
          w_su = 4'd9;
        end else if (r_mu != 4'd0) begin
          w_mu = r_mu - 4'd1;
          w_st = 4'd5;
          w_su = 4'd9;
        end else begin
          w_mt = r_mt - 4'd1;
          w_mu = 4'd9;
          w_st = 4'd5;
          w_su = 4'd9;
        end
      end else begin
        w_pre = r_pre + PW'(1);
      end
    end
  end

  assign w_done = ({w_mt, w_mu, w_st, w_su} == 16'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mt   <= 4'd0;
      r_mu   <= 4'd0;
      r_st   <= 4'd0;
      r_su   <= 4'd0;
      r_pre  <= '0;
      r_done <= 1'b1;
    end else begin
      r_mt   <= w_mt;
      r_mu   <= w_mu;
      r_st   <= w_st;
      r_su   <= w_su;
      r_pre  <= w_pre;
      r_done <= w_done;
    end
  end

  assign bus.min_tens   = r_mt;
  assign bus.min_units  = r_mu;
  assign bus.sec_tens   = r_st;
  assign bus.sec_units  = r_su;
  assign bus.timer_done = r_done;
endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer against a
// minutes/seconds arithmetic reference model.
module tb_microwave_timer;
  localparam int T = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  // Reference: time as a 4-digit decimal number MMSS
  int   m_n;
  int   m_pre;

  microwave_timer_if bif ();

  microwave_timer #(.TICKS_PER_SEC(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int obs_time();
    return {16'h0, bif.min_tens, bif.min_units,
            bif.sec_tens, bif.sec_units};
  endfunction

  function automatic int exp_time();
    int d3, d2, d1, d0;
    d3 = m_n / 1000;
    d2 = (m_n / 100) % 10;
    d1 = (m_n / 10) % 10;
    d0 = m_n % 10;
    return (d3 << 12) | (d2 << 8) | (d1 << 4) | d0;
  endfunction

  task automatic model_edge();
    int mm, ss;
    if (!bif.clearn) begin
      m_n   = 0;
      m_pre = 0;
    end else if (bif.digit_valid && !bif.enable &&
                 bif.digit <= 4'd9) begin
      m_n   = (m_n * 10 + int'(bif.digit)) % 10000;
      m_pre = 0;
    end else if (bif.enable && m_n != 0) begin
      m_pre++;
      if (m_pre == T) begin
        m_pre = 0;
        mm = m_n / 100;
        ss = m_n % 100;
        if (ss > 0) ss--;
        else begin
          mm--;
          ss = 59;
        end
        m_n = mm * 100 + ss;
      end
    end
  endtask

  task automatic step(input logic en, input logic dv,
                      input logic [3:0] d,
                      input logic clrn);
    bif.enable      = en;
    bif.digit_valid = dv;
    bif.digit       = d;
    bif.clearn      = clrn;
    @(posedge clk);
    model_edge();
    #1;
    chk("time", obs_time(), exp_time());
    chk("done", int'(bif.timer_done), int'(m_n == 0));
  endtask

  task automatic run(input logic en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 4'd0, 1'b1);
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b0, 1'b1, d, 1'b1);
  endtask

  initial begin
    logic en_r;
    total = 0;
    bad   = 0;
    m_n   = 0;
    m_pre = 0;
    bif.clearn      = 1'b1;
    bif.digit       = 4'd0;
    bif.digit_valid = 1'b0;
    bif.enable      = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_time", obs_time(), 0);
    chk("rst_done", int'(bif.timer_done), 1);
    reset = 1'b0;

    // Idle at 00:00 with enable must not wrap
    run(1'b1, 6);
    chk("idle_time", obs_time(), 0);

    key(4'd1); key(4'd3); key(4'd0);
    chk("ent_0130", obs_time(), 16'h0130);
    chk("ent_done", int'(bif.timer_done), 0);
    run(1'b1, 4);
    chk("t_0129", obs_time(), 16'h0129);
    run(1'b1, 120);
    chk("t_0059", obs_time(), 16'h0059);
    run(1'b1, 235);
    chk("pre_done", int'(bif.timer_done), 0);
    run(1'b1, 1);
    chk("done90", int'(bif.timer_done), 1);
    chk("zero90", obs_time(), 0);

    key(4'd9); key(4'd5);
    chk("ent_0095", obs_time(), 16'h0095);
    run(1'b1, 20);
    chk("t_0090", obs_time(), 16'h0090);
    run(1'b1, 4);
    chk("t_0089", obs_time(), 16'h0089);
    run(1'b1, 355);
    chk("pre_d95", int'(bif.timer_done), 0);
    run(1'b1, 1);
    chk("done95", int'(bif.timer_done), 1);

    // Pause keeps sub-second progress
    key(4'd1); key(4'd0);
    run(1'b1, 6);
    chk("p_0009", obs_time(), 16'h0009);
    run(1'b0, 20);
    chk("hold_0009", obs_time(), 16'h0009);
    run(1'b1, 1);
    chk("res1_0009", obs_time(), 16'h0009);
    run(1'b1, 1);
    chk("res2_0008", obs_time(), 16'h0008);

    step(1'b1, 1'b1, 4'd4, 1'b1);
    chk("en_ign", obs_time(), 16'h0008);
    step(1'b0, 1'b1, 4'd12, 1'b1);
    chk("bad_dig", obs_time(), 16'h0008);
    step(1'b0, 1'b1, 4'd7, 1'b0);
    chk("clr_win", obs_time(), 0);
    chk("clr_done", int'(bif.timer_done), 1);

    // Asynchronous reset mid-countdown
    key(4'd2); key(4'd0); key(4'd0);
    chk("ent_0200", obs_time(), 16'h0200);
    run(1'b1, 10);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_time", obs_time(), 0);
    chk("arst_done", int'(bif.timer_done), 1);
    m_n   = 0;
    m_pre = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    run(1'b1, 8);
    chk("post_rst", obs_time(), 0);

    en_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] d;
      logic dv, cl;
      if ($urandom_range(0, 99) < 3) en_r = ~en_r;
      dv = ($urandom_range(0, 9) < 3);
      d  = 4'($urandom_range(0, 15));
      cl = ($urandom_range(0, 499) != 0);
      step(en_r, dv, d, cl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
